// File: rtl/sub_serial_pkg.sv
// Shared types for the bit-serial subtractor: FSM state encoding.
package sub_serial_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

endpackage

// File: rtl/sub_1bit.sv
// One-bit full subtractor: d = a - b - bin, with borrow out.
module sub_1bit (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d    = a ^ b ^ bin;
    assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/sub_serial.sv
// Bit-serial subtractor: one operand bit per RUN cycle, LSB first, done pulse
// in the cycle after the last bit; result held until the next accepted start.
module sub_serial
    import sub_serial_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    state_t           state, state_nx;
    logic [WIDTH-1:0] a_sr, b_sr, diff_sr;
    logic [CW-1:0]    cnt;
    logic             borrow_q;
    logic             d_bit, bout_bit;
    logic             last_bit;

    assign last_bit = (cnt == CW'(WIDTH - 1));

    sub_1bit u_bit (
        .a    (a_sr[0]),
        .b    (b_sr[0]),
        .bin  (borrow_q),
        .d    (d_bit),
        .bout (bout_bit)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = RUN;
            RUN:     if (last_bit) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Result bits enter at the MSB so diff_sr is aligned after WIDTH shifts.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_sr     <= '0;
            b_sr     <= '0;
            diff_sr  <= '0;
            cnt      <= '0;
            borrow_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_sr     <= a;
                        b_sr     <= b;
                        cnt      <= '0;
                        borrow_q <= 1'b0;
                    end
                end
                RUN: begin
                    a_sr     <= a_sr >> 1;
                    b_sr     <= b_sr >> 1;
                    diff_sr  <= {d_bit, diff_sr[WIDTH-1:1]};
                    borrow_q <= bout_bit;
                    if (!last_bit) cnt <= cnt + CW'(1);
                end
                default: ;
            endcase
        end
    end

    assign busy       = (state != IDLE);
    assign done       = (state == DONE);
    assign diff       = diff_sr;
    assign borrow_out = borrow_q;

endmodule

// File: tb/tb_sub_serial.sv
// Self-checking bench for sub_serial (WIDTH=8): cycle-count reference model
// compared every cycle, plus directed literal checks.
module tb_sub_serial;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         busy, done, borrow_out;
    logic [W-1:0] diff;

    int errors = 0;
    int checks = 0;

    sub_serial #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .a          (a),
        .b          (b),
        .busy       (busy),
        .done       (done),
        .diff       (diff),
        .borrow_out (borrow_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: phase = rising edges since the accepting edge (0 = idle).
    // The result appears WIDTH+1 edges after acceptance and lasts one cycle as done.
    int         phase = 0;
    logic [W:0] pend;
    logic [W-1:0] m_diff = '0;
    logic       m_borrow = 1'b0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            phase    = 0;
            m_diff   = '0;
            m_borrow = 1'b0;
        end else if (phase == 0) begin
            if (start) begin
                pend  = {1'b0, a} - {1'b0, b};
                phase = 1;
            end
        end else if (phase == W + 1) begin
            phase = 0;
        end else begin
            phase++;
            if (phase == W + 1) {m_borrow, m_diff} = pend;
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            check("busy", busy, (phase != 0));
            check("done", done, (phase == W + 1));
            if (phase == 0 || phase == W + 1) begin
                check("diff", diff, m_diff);
                check("borrow_out", borrow_out, m_borrow);
            end
        end
    end

    task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb,
                          input logic [W-1:0] ed, input logic eb, input string tag);
        int n;
        start = 1'b1; a = ta; b = tb;
        @(posedge clk); #1;
        start = 1'b0;
        n = 1;
        while (!done && n < 20) begin
            a = W'($urandom);
            b = W'($urandom);
            @(posedge clk); #1;
            n++;
        end
        check({tag, "_edges"}, n, W + 1);
        check({tag, "_diff"}, diff, ed);
        check({tag, "_borrow"}, borrow_out, eb);
        check({tag, "_model"}, {m_borrow, m_diff}, {eb, ed});
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int         ndone, first_i, second_i, seen;
        logic [W:0] g;

        #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_diff", diff, 0);
        check("rst_borrow", borrow_out, 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;

        run_op(8'd5,   8'd3,   8'h02, 1'b0, "5m3");
        run_op(8'd3,   8'd5,   8'hFE, 1'b1, "3m5");
        run_op(8'h00,  8'h00,  8'h00, 1'b0, "0m0");
        run_op(8'hFF,  8'h00,  8'hFF, 1'b0, "FFm0");

        // start held high: one result per W+2 cycles, no queued requests
        start = 1'b1; a = 8'd9; b = 8'd4;
        ndone = 0; first_i = 0; second_i = 0;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk); #1;
            if (done) begin
                ndone++;
                if (ndone == 1) first_i = i; else second_i = i;
                check("hold_diff", diff, 8'h05);
            end
        end
        start = 1'b0;
        check("hold_count", ndone, 2);
        check("hold_spacing", second_i - first_i, W + 2);
        repeat (2) @(posedge clk); #1;

        // reset during the 4th RUN cycle
        start = 1'b1; a = 8'h37; b = 8'h12;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_diff", diff, 0);
        check("abort_borrow", borrow_out, 0);
        start = 1'b1;
        @(posedge clk); #1;
        check("rst_ignores_start", busy, 0);
        rst = 1'b0; start = 1'b0;
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (done || busy) seen++;
        end
        check("abort_no_done", seen, 0);
        run_op(8'h80, 8'h01, 8'h7F, 1'b0, "after_rst");

        for (int i = 0; i < 500; i++) begin
            logic [W-1:0] ra, rb;
            ra = W'($urandom);
            rb = W'($urandom);
            g  = {1'b0, ra} - {1'b0, rb};
            run_op(ra, rb, g[W-1:0], g[W], "rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
